cmp_sweep_driver: RTL and testbench

- Initiator for the 4-bit comparison unit.
- Accepts one operand pair over a valid/ready handshake and packs it into the comparator's 8-bit operand bus.
- Steps the comparator's 2-bit select through all four operations (equal, greater, less, max) and samples each result.
- Returns the collected verdict on a second valid/ready handshake.
- Sits between the operand source (switch/controller logic) and the combinational comparator.

---
 rtl/cmp_sweep_driver.sv | 163 ++++++++++++++++
 tb/tb_cmp_sweep_driver.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmp_sweep_driver.sv
// cmp_sweep_driver: accepts one 4-bit operand pair, drives it onto the
// comparator operand bus, steps the comparator select through
// equal/greater/less/max, samples each result and returns the verdict.
// Optional build macro: CMP_CHECK_EN enables a sticky self-consistency
// check of the collected verdict against the registered operands.
module cmp_sweep_driver #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_a,
    input  logic [3:0] in_b,
    output logic [7:0] cmp_z,
    output logic [1:0] cmp_sel,
    input  logic [3:0] cmp_result,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_eq,
    output logic       out_gt,
    output logic       out_lt,
    output logic [3:0] out_max,
    output logic       chk_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam logic [3:0] RELOAD = 4'(SETTLE_CYCLES - 1);

    state_e     state_q, state_d;
    logic [7:0] z_q, z_d;
    logic [1:0] sel_q, sel_d;
    logic [3:0] cnt_q, cnt_d;
    // Sampled flags stay internal until the whole sweep is done.
    logic       eq_q, eq_d, gt_q, gt_d, lt_q, lt_d;
    logic       oeq_q, oeq_d, ogt_q, ogt_d, olt_q, olt_d;
    logic [3:0] omax_q, omax_d;
    logic       ovalid_q, ovalid_d;
    logic       chk_q, chk_d;
    logic       mismatch;

`ifdef CMP_CHECK_EN
    logic [3:0] op_a, op_b;
    assign op_a = z_q[3:0];
    assign op_b = z_q[7:4];

    // Verdict must agree with plain arithmetic on the operands; max is taken
    // straight from the comparator since it is sampled on the DONE-entry edge.
    always_comb begin
        mismatch = (eq_q != (op_a == op_b)) ||
                   (gt_q != (op_a >  op_b)) ||
                   (lt_q != (op_a <  op_b)) ||
                   (cmp_result != ((op_a > op_b) ? op_a : op_b));
    end
`else
    assign mismatch = 1'b0;
`endif

    // Next-state: accept, step the select per settle window, hold verdict.
    always_comb begin
        state_d  = state_q;
        z_d      = z_q;
        sel_d    = sel_q;
        cnt_d    = cnt_q;
        eq_d     = eq_q;
        gt_d     = gt_q;
        lt_d     = lt_q;
        oeq_d    = oeq_q;
        ogt_d    = ogt_q;
        olt_d    = olt_q;
        omax_d   = omax_q;
        ovalid_d = ovalid_q;
        chk_d    = chk_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    z_d     = {in_b, in_a};
                    sel_d   = 2'b00;
                    cnt_d   = RELOAD;
                    state_d = SWEEP;
                end
            end
            SWEEP: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    cnt_d = RELOAD;
                    case (sel_q)
                        2'b00: eq_d = cmp_result[0];
                        2'b01: gt_d = cmp_result[0];
                        2'b10: lt_d = cmp_result[0];
                        default: begin
                            state_d  = DONE;
                            oeq_d    = eq_q;
                            ogt_d    = gt_q;
                            olt_d    = lt_q;
                            omax_d   = cmp_result;
                            ovalid_d = 1'b1;
                            chk_d    = chk_q | mismatch;
                        end
                    endcase
                    if (sel_q != 2'b11) sel_d = sel_q + 2'd1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    ovalid_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; everything clears on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            z_q      <= 8'h00;
            sel_q    <= 2'b00;
            cnt_q    <= 4'd0;
            eq_q     <= 1'b0;
            gt_q     <= 1'b0;
            lt_q     <= 1'b0;
            oeq_q    <= 1'b0;
            ogt_q    <= 1'b0;
            olt_q    <= 1'b0;
            omax_q   <= 4'd0;
            ovalid_q <= 1'b0;
            chk_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            z_q      <= z_d;
            sel_q    <= sel_d;
            cnt_q    <= cnt_d;
            eq_q     <= eq_d;
            gt_q     <= gt_d;
            lt_q     <= lt_d;
            oeq_q    <= oeq_d;
            ogt_q    <= ogt_d;
            olt_q    <= olt_d;
            omax_q   <= omax_d;
            ovalid_q <= ovalid_d;
            chk_q    <= chk_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign cmp_z     = z_q;
    assign cmp_sel   = sel_q;
    assign out_valid = ovalid_q;
    assign out_eq    = oeq_q;
    assign out_gt    = ogt_q;
    assign out_lt    = olt_q;
    assign out_max   = omax_q;
    assign chk_err   = chk_q;

endmodule

// File: tb/tb_cmp_sweep_driver.sv
// Bench for cmp_sweep_driver: two instances (settle 1 and settle 3), each
// fed by a behavioural comparator; a timeline model predicts every output.
module tb_cmp_sweep_driver;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid [2];
    logic       in_ready [2];
    logic [3:0] in_a [2];
    logic [3:0] in_b [2];
    logic [7:0] cmp_z [2];
    logic [1:0] cmp_sel [2];
    logic [3:0] cmp_result [2];
    logic       out_valid [2];
    logic       out_ready [2];
    logic       out_eq [2];
    logic       out_gt [2];
    logic       out_lt [2];
    logic [3:0] out_max [2];
    logic       chk_err [2];
    logic       stub [2];

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    cmp_sweep_driver #(.SETTLE_CYCLES(1)) u0 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_a(in_a[0]), .in_b(in_b[0]),
        .cmp_z(cmp_z[0]), .cmp_sel(cmp_sel[0]), .cmp_result(cmp_result[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_eq(out_eq[0]), .out_gt(out_gt[0]), .out_lt(out_lt[0]),
        .out_max(out_max[0]), .chk_err(chk_err[0])
    );

    cmp_sweep_driver #(.SETTLE_CYCLES(3)) u1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_a(in_a[1]), .in_b(in_b[1]),
        .cmp_z(cmp_z[1]), .cmp_sel(cmp_sel[1]), .cmp_result(cmp_result[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_eq(out_eq[1]), .out_gt(out_gt[1]), .out_lt(out_lt[1]),
        .out_max(out_max[1]), .chk_err(chk_err[1])
    );

    function automatic int settle(int i);
        return (i == 0) ? 1 : 3;
    endfunction

    // Behavioural 4-bit comparator: x = low nibble, y = high nibble.
    function automatic logic [3:0] cmp_fn(logic [7:0] z, logic [1:0] s);
        logic [3:0] x, y;
        x = z[3:0];
        y = z[7:4];
        case (s)
            2'b00:   return {3'b000, x == y};
            2'b01:   return {3'b000, x > y};
            2'b10:   return {3'b000, x < y};
            default: return (x > y) ? x : y;
        endcase
    endfunction

    always_comb begin
        cmp_result[0] = stub[0] ? 4'h0 : cmp_fn(cmp_z[0], cmp_sel[0]);
        cmp_result[1] = stub[1] ? 4'h0 : cmp_fn(cmp_z[1], cmp_sel[1]);
    end

    task automatic chk(string name, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Timeline model: phase 0 idle, 1 sweeping (j edges since accept), 2 done.
    int         m_ph [2];
    int         m_j [2];
    logic [3:0] m_a [2], m_b [2], m_max [2];
    logic [7:0] m_z [2];
    logic [1:0] m_sel [2];
    logic       m_eq [2], m_gt [2], m_lt [2], m_chk [2];

    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                m_ph[i] = 0; m_j[i] = 0; m_z[i] = 8'h00; m_sel[i] = 2'b00;
                m_eq[i] = 1'b0; m_gt[i] = 1'b0; m_lt[i] = 1'b0;
                m_max[i] = 4'h0; m_chk[i] = 1'b0;
                m_a[i] = 4'h0; m_b[i] = 4'h0;
            end else begin
                case (m_ph[i])
                    0: if (in_valid[i]) begin
                        m_a[i] = in_a[i]; m_b[i] = in_b[i];
                        m_z[i] = {in_b[i], in_a[i]};
                        m_sel[i] = 2'b00; m_j[i] = 0; m_ph[i] = 1;
                    end
                    1: begin
                        m_j[i]++;
                        if (m_j[i] == 4 * settle(i)) begin
                            m_ph[i] = 2;
                            if (stub[i]) begin
                                m_eq[i] = 1'b0; m_gt[i] = 1'b0; m_lt[i] = 1'b0; m_max[i] = 4'h0;
`ifdef CMP_CHECK_EN
                                m_chk[i] = 1'b1;
`endif
                            end else begin
                                m_eq[i] = (m_a[i] == m_b[i]);
                                m_gt[i] = (m_a[i] > m_b[i]);
                                m_lt[i] = (m_a[i] < m_b[i]);
                                m_max[i] = (m_a[i] > m_b[i]) ? m_a[i] : m_b[i];
                            end
                        end else begin
                            m_sel[i] = 2'(m_j[i] / settle(i));
                        end
                    end
                    default: if (out_ready[i]) m_ph[i] = 0;
                endcase
            end
        end
    end

    // Compare every output of both instances against the model each cycle.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("u%0d in_ready", i), in_ready[i], m_ph[i] == 0);
            chk($sformatf("u%0d out_valid", i), out_valid[i], m_ph[i] == 2);
            chk($sformatf("u%0d cmp_z", i), cmp_z[i], m_z[i]);
            chk($sformatf("u%0d cmp_sel", i), cmp_sel[i], m_sel[i]);
            chk($sformatf("u%0d out_eq", i), out_eq[i], m_eq[i]);
            chk($sformatf("u%0d out_gt", i), out_gt[i], m_gt[i]);
            chk($sformatf("u%0d out_lt", i), out_lt[i], m_lt[i]);
            chk($sformatf("u%0d out_max", i), out_max[i], m_max[i]);
            chk($sformatf("u%0d chk_err", i), chk_err[i], m_chk[i]);
        end
    end

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    // Drive one pair, check the select walk, latency and verdict literals.
    task automatic send(int i, logic [3:0] a, logic [3:0] b, int lat,
                        logic e, logic g, logic l, logic [3:0] mx);
        int k;
        in_a[i] = a; in_b[i] = b; in_valid[i] = 1'b1;
        tick;
        in_valid[i] = 1'b0;
        chk("lit cmp_z at accept", cmp_z[i], {b, a});
        k = 0;
        while (!out_valid[i] && k < 200) begin
            if (k < 4 * settle(i)) chk("lit sel walk", cmp_sel[i], k / settle(i));
            tick;
            k++;
        end
        chk("lit latency", k, lat);
        chk("lit eq", out_eq[i], e);
        chk("lit gt", out_gt[i], g);
        chk("lit lt", out_lt[i], l);
        chk("lit max", out_max[i], mx);
        if (out_ready[i]) begin
            tick;
            chk("lit valid drop", out_valid[i], 0);
            chk("lit ready back", in_ready[i], 1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid[i] = 1'b0; in_a[i] = 4'h0; in_b[i] = 4'h0;
            out_ready[i] = 1'b1; stub[i] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        chk("rst in_ready", in_ready[0], 1);
        chk("rst out_valid", out_valid[0], 0);
        chk("rst cmp_z", cmp_z[0], 8'h00);
        chk("rst cmp_sel", cmp_sel[0], 0);
        chk("rst chk_err", chk_err[0], 0);

        send(0, 4'h9, 4'h3, 4, 1'b0, 1'b1, 1'b0, 4'h9);
        send(0, 4'h5, 4'h5, 4, 1'b1, 1'b0, 1'b0, 4'h5);
        send(0, 4'h0, 4'hF, 4, 1'b0, 1'b0, 1'b1, 4'hF);

        // Back-pressure with a competing pair held on the input.
        out_ready[0] = 1'b0;
        send(0, 4'hC, 4'h2, 4, 1'b0, 1'b1, 1'b0, 4'hC);
        for (int n = 0; n < 6; n++) begin
            if (n == 1) begin
                in_a[0] = 4'h1; in_b[0] = 4'h2; in_valid[0] = 1'b1;
            end
            tick;
            chk("bp valid hold", out_valid[0], 1);
            chk("bp ready low", in_ready[0], 0);
            chk("bp max hold", out_max[0], 4'hC);
            chk("bp gt hold", out_gt[0], 1);
        end
        out_ready[0] = 1'b1;
        tick;
        chk("bp valid drop", out_valid[0], 0);
        chk("bp ready rise", in_ready[0], 1);
        tick;
        chk("held pair accepted", in_ready[0], 0);
        chk("held pair z", cmp_z[0], 8'h21);
        in_valid[0] = 1'b0;
        k = 0;
        while (!out_valid[0] && k < 50) begin
            tick;
            k++;
        end
        chk("held pair latency", k, 4);
        chk("held pair lt", out_lt[0], 1);
        chk("held pair max", out_max[0], 4'h2);
        tick;

        // Longer settle window.
        send(1, 4'h7, 4'h8, 12, 1'b0, 1'b0, 1'b1, 4'h8);

        // Reset while sel 10 is on the bus.
        in_a[0] = 4'h9; in_b[0] = 4'h3; in_valid[0] = 1'b1;
        tick;
        in_valid[0] = 1'b0;
        tick;
        tick;
        chk("mid sel before rst", cmp_sel[0], 2);
        #1 rst_n = 1'b0;
        #1;
        chk("mid rst in_ready", in_ready[0], 1);
        chk("mid rst cmp_z", cmp_z[0], 8'h00);
        chk("mid rst cmp_sel", cmp_sel[0], 0);
        chk("mid rst max", out_max[0], 0);
        chk("mid rst lt", out_lt[0], 0);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        chk("mid rst release ready", in_ready[0], 1);
        send(0, 4'h6, 4'h4, 4, 1'b0, 1'b1, 1'b0, 4'h6);

`ifdef CMP_CHECK_EN
        stub[0] = 1'b1;
        send(0, 4'h3, 4'h1, 4, 1'b0, 1'b0, 1'b0, 4'h0);
        stub[0] = 1'b0;
        chk("chk_err set", chk_err[0], 1);
        send(0, 4'h2, 4'h2, 4, 1'b1, 1'b0, 1'b0, 4'h2);
        chk("chk_err sticky", chk_err[0], 1);
`endif

        tick;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
